button_event_fifo: RTL and testbench

// - Input-side counterpart of the per-digit display path: turns debounced, active-high button levels into discrete events.
// - Queues the events in a small FIFO that the platform CPU drains through a pop strobe.
// - Sits between the button_debouncer instances and the CPU inputs port.
// - Lets software consume every press, instead of sampling levels and missing short presses.

---
 rtl/button_event_fifo.sv | 135 +++++++++++++
 tb/tb_button_event_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fifo.sv
// Turns debounced button levels into press (and optionally release) events queued in a show-ahead FIFO.
// Define BTN_EVT_RELEASE_EN to also queue release events (type bit 0).
module button_event_fifo #(
    parameter int unsigned NUM_BUTTONS = 4,
    parameter int unsigned DEPTH       = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_BUTTONS),
    localparam int unsigned EVT_W      = IDX_W + 1,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   pop,
    output logic                   evt_valid,
    output logic [EVT_W-1:0]       evt_data,
    output logic [CNT_W-1:0]       evt_count,
    output logic                   overflow,
    input  logic                   clear_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [NUM_BUTTONS-1:0] prev_q;
    logic [NUM_BUTTONS-1:0] press_pend_q, press_pend_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [EVT_W-1:0]       mem_q [DEPTH];

    logic [NUM_BUTTONS-1:0] press_edge;
    logic [NUM_BUTTONS-1:0] press_clr;
    logic [NUM_BUTTONS-1:0] grant_onehot;
    logic                   grant_valid;
    logic                   grant_type;
    logic [IDX_W-1:0]       grant_idx;
    logic                   full;
    logic                   pop_eff;
    logic                   push;
    logic                   ovf_set;

`ifdef BTN_EVT_RELEASE_EN
    logic [NUM_BUTTONS-1:0] rel_pend_q, rel_pend_d;
    logic [NUM_BUTTONS-1:0] rel_edge;
    logic [NUM_BUTTONS-1:0] rel_clr;
`endif

    assign press_edge = buttons & ~prev_q;
`ifdef BTN_EVT_RELEASE_EN
    assign rel_edge   = ~buttons & prev_q;
`endif

    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_eff = pop && (count_q != '0);

    // Lowest index wins; at one index a pending press beats a pending release.
    always_comb begin
        grant_valid = 1'b0;
        grant_type  = 1'b1;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            if (!grant_valid && press_pend_q[i]) begin
                grant_valid = 1'b1;
                grant_type  = 1'b1;
                grant_idx   = IDX_W'(i);
            end
`ifdef BTN_EVT_RELEASE_EN
            else if (!grant_valid && rel_pend_q[i]) begin
                grant_valid = 1'b1;
                grant_type  = 1'b0;
                grant_idx   = IDX_W'(i);
            end
`endif
        end
    end

    assign push         = grant_valid && (!full || pop_eff);
    assign grant_onehot = NUM_BUTTONS'(1) << grant_idx;

    always_comb begin
        press_clr    = (push && grant_type) ? grant_onehot : '0;
        press_pend_d = (press_pend_q & ~press_clr) | press_edge;
        ovf_set      = |(press_edge & press_pend_q & ~press_clr);
`ifdef BTN_EVT_RELEASE_EN
        rel_clr      = (push && !grant_type) ? grant_onehot : '0;
        rel_pend_d   = (rel_pend_q & ~rel_clr) | rel_edge;
        ovf_set      = ovf_set | (|(rel_edge & rel_pend_q & ~rel_clr));
`endif
        ovf_d        = ovf_set ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
        wr_ptr_d     = push    ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop_eff ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q       <= '0;
            press_pend_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            prev_q       <= buttons;
            press_pend_q <= press_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef BTN_EVT_RELEASE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_pend_q <= '0;
        end else begin
            rel_pend_q <= rel_pend_d;
        end
    end
`endif

    // Storage needs no reset: evt_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_type, grant_idx};
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed bench for button_event_fifo with an expected-event scoreboard queue.
// Expectations follow BTN_EVT_RELEASE_EN when it is defined for the build.
module tb_button_event_fifo;

    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EVT_W = 3;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NB-1:0]    buttons;
    logic             pop;
    logic             clear_ovf;
    logic             evt_valid;
    logic [EVT_W-1:0] evt_data;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    int unsigned total  = 0;
    int unsigned passes = 0;
    logic [EVT_W-1:0] exp_q [$];

    button_event_fifo #(.NUM_BUTTONS(NB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .buttons   (buttons),
        .pop       (pop),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Drives a new button vector and records the events it should create, in index order.
    task automatic set_buttons(input logic [NB-1:0] nb);
        for (int i = 0; i < NB; i++) begin
            if (nb[i] && !buttons[i]) exp_q.push_back({1'b1, 2'(i)});
`ifdef BTN_EVT_RELEASE_EN
            if (!nb[i] && buttons[i]) exp_q.push_back({1'b0, 2'(i)});
`endif
        end
        buttons = nb;
    endtask

    task automatic consume(input string tag);
        logic [EVT_W-1:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_data"}, 32'(evt_data), 32'(e));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned budget = 64;
        while (exp_q.size() > 0 && budget > 0) begin
            consume(tag);
            budget--;
        end
        chk({tag, "_empty"}, 32'(evt_valid), 32'd0);
        chk({tag, "_cnt0"}, 32'(evt_count), 32'd0);
    endtask

    task automatic toggle_until(input int unsigned bit_i, input int unsigned n);
        int unsigned budget = 64;
        while (exp_q.size() < n && budget > 0) begin
            logic [NB-1:0] nb;
            nb = buttons;
            nb[bit_i] = ~nb[bit_i];
            set_buttons(nb);
            tick();
            tick();
            budget--;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; buttons = '0; pop = 1'b0; clear_ovf = 1'b0;
        #12;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_data", 32'(evt_data), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();

        // Single press of button 2: visible two edges later.
        set_buttons(4'b0100);
        tick();
        chk("t1_lat1", 32'(evt_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(evt_valid), 32'd1);
        chk("t1_data", 32'(evt_data), 32'b110);
        chk("t1_count", 32'(evt_count), 32'd1);
        drain("t1");
        set_buttons(4'b0000);
        tick(); tick();
        drain("t1r");

        // Simultaneous presses drain in index order.
        set_buttons(4'b1011);
        repeat (4) tick();
        chk("t2_count", 32'(evt_count), 32'd3);
        chk("t2_ovf", 32'(overflow), 32'd0);
        drain("t2");
        set_buttons(4'b0000);
        repeat (4) tick();
        drain("t2r");

        // Nine events with no pop: eight queued, the ninth held pending.
        toggle_until(0, 9);
        chk("t3_full", 32'(evt_count), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd0);
        consume("t3_pop");
        chk("t3_cnt_after_pop", 32'(evt_count), 32'd8);
        tick();
        chk("t3_cnt_stable", 32'(evt_count), 32'd8);
        chk("t3_ovf2", 32'(overflow), 32'd0);
        drain("t3");
        set_buttons(4'b0000);
        tick(); tick();
        drain("t3r");

        // Merge while full sets overflow; set beats clear.
        toggle_until(1, 8);
        chk("t4_full", 32'(evt_count), 32'd8);
        set_buttons(4'b0001);
        tick(); tick();
        buttons = 4'b0000;
`ifdef BTN_EVT_RELEASE_EN
        exp_q.push_back(3'b000);
`endif
        tick(); tick();
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        buttons = 4'b0001;
        tick();
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        buttons = 4'b0000;
        tick(); tick();
        buttons = 4'b0001;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t4_set_wins", 32'(overflow), 32'd1);
        chk("t4_full2", 32'(evt_count), 32'd8);
        drain("t4");
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        buttons = 4'b0000;
`ifdef BTN_EVT_RELEASE_EN
        exp_q.push_back(3'b000);
`endif
        tick(); tick();
        drain("t4r");

        // Pop on empty is ignored.
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t5_empty_pop_cnt", 32'(evt_count), 32'd0);
        chk("t5_empty_pop_valid", 32'(evt_valid), 32'd0);

        // Async reset in the middle of a drain.
        toggle_until(2, 5);
        chk("t5_cnt5", 32'(evt_count), 32'd5);
        pop = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(evt_valid), 32'd0);
        chk("t5_rst_data", 32'(evt_data), 32'd0);
        chk("t5_rst_count", 32'(evt_count), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        pop = 1'b0;
        exp_q.delete();
        buttons = 4'b1000;
        tick();

        // Button held through reset produces one press.
        reset = 1'b1;
        exp_q.push_back(3'b111);
        tick(); tick();
        chk("t5_held_cnt", 32'(evt_count), 32'd1);
        drain("t5h");
        set_buttons(4'b0000);
        tick(); tick();
        drain("t5hr");

        // Press then release of button 1.
        set_buttons(4'b0010);
        tick(); tick();
        set_buttons(4'b0000);
        tick(); tick();
`ifdef BTN_EVT_RELEASE_EN
        chk("t6_count", 32'(evt_count), 32'd2);
`else
        chk("t6_count", 32'(evt_count), 32'd1);
`endif
        drain("t6");
        chk("t6_ovf", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
